// File: rtl/isolde_exec_dispatcher.sv
// isolde_exec_dispatcher
//   Execution-side responder for the ISOLDE fetch-to-exec handshake. Captures
//   one decoded instruction from the decoder, grants it, issues it to the
//   attached accelerator, waits for completion and writes a scalar result back
//   to the X register file. One instruction in flight.
//
//   Optional build macro: ISOLDE_EXEC_TIMEOUT_EN enables a WAIT_DONE watchdog
//   of TIMEOUT_CYCLES cycles that raises err_o and returns to IDLE.
//
// Ports
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   exec_req_i / exec_gnt_o / flush_i  decoder handshake and abort
//   opcode_i, func3_i, funct2_i, instr_i, rd_addr_i, imm32_i, imm32_valid_i,
//   rs1/2/3_data_i                     instruction payload (valid with req)
//   acc_valid_o / acc_ready_i          accelerator issue handshake
//   acc_opcode_o .. acc_imm_o          latched payload towards accelerator
//   acc_done_i, acc_wb_i, acc_result_i, acc_err_i   completion
//   x_we_o, x_waddr_o, x_wdata_o       X register-file write port
//   busy_o, err_o, retired_cnt_o       status
module isolde_exec_dispatcher #(
  parameter int unsigned OPC_W          = 4,
  parameter int unsigned IMM_WORDS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           exec_req_i,
  output logic                           exec_gnt_o,
  input  logic                           flush_i,
  input  logic [OPC_W-1:0]               opcode_i,
  input  logic [2:0]                     func3_i,
  input  logic [1:0]                     funct2_i,
  input  logic [31:0]                    instr_i,
  input  logic [4:0]                     rd_addr_i,
  input  logic [IMM_WORDS-1:0][31:0]     imm32_i,
  input  logic [IMM_WORDS-1:0]           imm32_valid_i,
  input  logic [31:0]                    rs1_data_i,
  input  logic [31:0]                    rs2_data_i,
  input  logic [31:0]                    rs3_data_i,
  output logic                           acc_valid_o,
  input  logic                           acc_ready_i,
  output logic [OPC_W-1:0]               acc_opcode_o,
  output logic [2:0]                     acc_func3_o,
  output logic [1:0]                     acc_funct2_o,
  output logic [31:0]                    acc_instr_o,
  output logic [2:0][31:0]               acc_rs_o,
  output logic [IMM_WORDS-1:0][31:0]     acc_imm_o,
  input  logic                           acc_done_i,
  input  logic                           acc_wb_i,
  input  logic [31:0]                    acc_result_i,
  input  logic                           acc_err_i,
  output logic                           x_we_o,
  output logic [4:0]                     x_waddr_o,
  output logic [31:0]                    x_wdata_o,
  output logic                           busy_o,
  output logic                           err_o,
  output logic [31:0]                    retired_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_ISSUE, S_WAIT, S_WB
  } state_e;

  state_e state_q, state_d;

  logic [OPC_W-1:0]           opcode_q;
  logic [2:0]                 func3_q;
  logic [1:0]                 funct2_q;
  logic [31:0]                instr_q;
  logic [4:0]                 rd_q;
  logic [2:0][31:0]           rs_q;
  logic [IMM_WORDS-1:0][31:0] imm_q;
  logic [31:0]                result_q;
  logic [31:0]                retired_q;
  logic                       drop_q;
  logic                       err_q;

  // next-state strobes
  logic capture, issue_hs, done_cap, set_drop, err_set, retire;

`ifdef ISOLDE_EXEC_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_q;
`endif

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    issue_hs = 1'b0;
    done_cap = 1'b0;
    set_drop = 1'b0;
    err_set  = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (exec_req_i && !flush_i) begin
          capture = 1'b1;
          state_d = S_GRANT;
        end
      end
      // The grant is decoded from state, so a flush here only suppresses the
      // issue; the pulse already on the wire cannot be withdrawn.
      S_GRANT: state_d = flush_i ? S_IDLE : S_ISSUE;
      S_ISSUE: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (acc_ready_i) begin
          issue_hs = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (acc_done_i) begin
          done_cap = 1'b1;
          state_d  = S_IDLE;
          if (acc_err_i) begin
            err_set = 1'b1;
          end else if (drop_q || flush_i) begin
            // dropped: result discarded, not counted
          end else if (acc_wb_i && (rd_q != 5'd0)) begin
            state_d = S_WB;
          end else begin
            retire = 1'b1;
          end
        end else begin
          if (flush_i) set_drop = 1'b1;
`ifdef ISOLDE_EXEC_TIMEOUT_EN
          if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            err_set = 1'b1;
            state_d = S_IDLE;
          end
`endif
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      func3_q   <= '0;
      funct2_q  <= '0;
      instr_q   <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      imm_q     <= '0;
      result_q  <= '0;
      retired_q <= '0;
      drop_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        opcode_q <= opcode_i;
        func3_q  <= func3_i;
        funct2_q <= funct2_i;
        instr_q  <= instr_i;
        rd_q     <= rd_addr_i;
        rs_q     <= {rs3_data_i, rs2_data_i, rs1_data_i};
        // invalid immediate slots are zeroed once, at capture
        for (int k = 0; k < int'(IMM_WORDS); k++)
          imm_q[k] <= imm32_valid_i[k] ? imm32_i[k] : 32'd0;
      end
      if (capture)       drop_q <= 1'b0;
      else if (set_drop) drop_q <= 1'b1;
      if (done_cap) result_q <= acc_result_i;
      err_q <= err_set;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

`ifdef ISOLDE_EXEC_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni)               wd_q <= '0;
    else if (issue_hs)         wd_q <= '0;
    else if (state_q == S_WAIT) wd_q <= wd_q + WD_W'(1);
  end
`endif

  assign exec_gnt_o    = (state_q == S_GRANT);
  assign acc_valid_o   = (state_q == S_ISSUE);
  assign busy_o        = (state_q != S_IDLE);
  assign x_we_o        = (state_q == S_WB);
  assign x_waddr_o     = (state_q == S_WB) ? rd_q : 5'd0;
  assign x_wdata_o     = (state_q == S_WB) ? result_q : 32'd0;
  assign err_o         = err_q;
  assign retired_cnt_o = retired_q;
  assign acc_opcode_o  = opcode_q;
  assign acc_func3_o   = func3_q;
  assign acc_funct2_o  = funct2_q;
  assign acc_instr_o   = instr_q;
  assign acc_rs_o      = rs_q;
  assign acc_imm_o     = imm_q;

endmodule

// File: tb/tb_isolde_exec_dispatcher.sv
module tb_isolde_exec_dispatcher;
  logic              clk_i = 1'b0, rst_ni = 1'b0;
  logic              exec_req_i = 0, exec_gnt_o, flush_i = 0;
  logic [3:0]        opcode_i = 0;
  logic [2:0]        func3_i = 0;
  logic [1:0]        funct2_i = 0;
  logic [31:0]       instr_i = 0;
  logic [4:0]        rd_addr_i = 0;
  logic [3:0][31:0]  imm32_i = '0;
  logic [3:0]        imm32_valid_i = 0;
  logic [31:0]       rs1_data_i = 0, rs2_data_i = 0, rs3_data_i = 0;
  logic              acc_valid_o, acc_ready_i = 0;
  logic [3:0]        acc_opcode_o;
  logic [2:0]        acc_func3_o;
  logic [1:0]        acc_funct2_o;
  logic [31:0]       acc_instr_o;
  logic [2:0][31:0]  acc_rs_o;
  logic [3:0][31:0]  acc_imm_o;
  logic              acc_done_i = 0, acc_wb_i = 0, acc_err_i = 0;
  logic [31:0]       acc_result_i = 0;
  logic              x_we_o;
  logic [4:0]        x_waddr_o;
  logic [31:0]       x_wdata_o;
  logic              busy_o, err_o;
  logic [31:0]       retired_cnt_o;

  isolde_exec_dispatcher #(.OPC_W(4), .IMM_WORDS(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .exec_req_i(exec_req_i), .exec_gnt_o(exec_gnt_o),
    .flush_i(flush_i), .opcode_i(opcode_i), .func3_i(func3_i), .funct2_i(funct2_i),
    .instr_i(instr_i), .rd_addr_i(rd_addr_i), .imm32_i(imm32_i),
    .imm32_valid_i(imm32_valid_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .rs3_data_i(rs3_data_i), .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i),
    .acc_opcode_o(acc_opcode_o), .acc_func3_o(acc_func3_o), .acc_funct2_o(acc_funct2_o),
    .acc_instr_o(acc_instr_o), .acc_rs_o(acc_rs_o), .acc_imm_o(acc_imm_o),
    .acc_done_i(acc_done_i), .acc_wb_i(acc_wb_i), .acc_result_i(acc_result_i),
    .acc_err_i(acc_err_i), .x_we_o(x_we_o), .x_waddr_o(x_waddr_o), .x_wdata_o(x_wdata_o),
    .busy_o(busy_o), .err_o(err_o), .retired_cnt_o(retired_cnt_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] opc; logic [2:0] f3; logic [1:0] f2; logic [31:0] instr;
    logic [4:0] rd; logic [31:0] rs1, rs2, rs3;
    logic [3:0][31:0] imm; logic [3:0] immv;
    int rdy_dly; int done_dly; int fl;       // fl: 0 none, 1 in ISSUE, 2 in WAIT_DONE
    logic wb; logic err; logic [31:0] res;
    logic exp_we; logic [4:0] exp_waddr; logic [31:0] exp_wdata;
    int exp_ret; int exp_err; logic [3:0][31:0] exp_imm;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  int gnt_cnt = 0, err_cnt = 0;
  logic [36:0] wq[$];

  // passive observer of pulses and register-file writes
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (exec_gnt_o) gnt_cnt++;
      if (err_o) err_cnt++;
      if (x_we_o) wq.push_back({x_waddr_o, x_wdata_o});
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " ctl"}, {exec_gnt_o, acc_valid_o, x_we_o, busy_o, err_o}, 0);
    chk({nm, " wb"}, {x_waddr_o, x_wdata_o, retired_cnt_o}, 0);
    chk({nm, " acc"}, {acc_opcode_o, acc_func3_o, acc_funct2_o, acc_instr_o}, 0);
    chk({nm, " accd"}, {acc_rs_o, acc_imm_o}, 0);
  endtask

  function automatic vec_t mk(input logic [3:0] opc, input logic [2:0] f3, input logic [1:0] f2,
      input logic [31:0] instr, input logic [4:0] rd, input logic [31:0] rs1,
      input logic [127:0] imm, input logic [3:0] immv, input int rdy, input int dn,
      input int fl, input logic wb, input logic err, input logic [31:0] res,
      input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd, input int eret,
      input int eerr, input logic [127:0] eimm);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.f2 = f2; v.instr = instr; v.rd = rd;
    v.rs1 = rs1; v.rs2 = rs1 ^ 32'h5555_5555; v.rs3 = ~rs1;
    v.imm = imm; v.immv = immv; v.rdy_dly = rdy; v.done_dly = dn; v.fl = fl;
    v.wb = wb; v.err = err; v.res = res;
    v.exp_we = ewe; v.exp_waddr = ewa; v.exp_wdata = ewd;
    v.exp_ret = eret; v.exp_err = eerr; v.exp_imm = eimm;
    return v;
  endfunction

  // transaction-level reference: outcome of one instruction from the rules
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    for (int k = 0; k < 4; k++) r.exp_imm[k] = v.immv[k] ? v.imm[k] : 32'd0;
    r.exp_we = 0; r.exp_waddr = 0; r.exp_wdata = 0; r.exp_ret = 0; r.exp_err = 0;
    if (v.fl == 1) return r;
    if (v.err) r.exp_err = 1;
    else if (v.fl == 2) r.exp_ret = 0;
    else begin
      r.exp_ret = 1;
      if (v.wb && v.rd != 0) begin r.exp_we = 1; r.exp_waddr = v.rd; r.exp_wdata = v.res; end
    end
    return r;
  endfunction

  task automatic scramble();
    opcode_i = 4'($urandom); func3_i = 3'($urandom); funct2_i = 2'($urandom);
    instr_i = $urandom; rd_addr_i = 5'($urandom); imm32_valid_i = 4'($urandom);
    imm32_i = {$urandom, $urandom, $urandom, $urandom};
    rs1_data_i = $urandom; rs2_data_i = $urandom; rs3_data_i = $urandom;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int g0, e0, w0; logic [31:0] r0; bit ok;
    g0 = gnt_cnt; e0 = err_cnt; w0 = wq.size(); r0 = retired_cnt_o;
    @(negedge clk_i);
    exec_req_i = 1; opcode_i = v.opc; func3_i = v.f3; funct2_i = v.f2; instr_i = v.instr;
    rd_addr_i = v.rd; imm32_i = v.imm; imm32_valid_i = v.immv;
    rs1_data_i = v.rs1; rs2_data_i = v.rs2; rs3_data_i = v.rs3;
    @(posedge clk_i); #1 exec_req_i = 0; scramble();
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (acc_valid_o) begin ok = 1; break; end
    end
    chk({tag, " valid seen"}, ok, 1);
    if (ok) begin
      for (int c = 0; c <= v.rdy_dly; c++) begin
        chk({tag, " acc ctl"}, {acc_opcode_o, acc_func3_o, acc_funct2_o, acc_instr_o},
            {v.opc, v.f3, v.f2, v.instr});
        chk({tag, " acc rs"}, acc_rs_o, {v.rs3, v.rs2, v.rs1});
        chk({tag, " acc imm"}, acc_imm_o, v.exp_imm);
        if (c == v.rdy_dly) begin
          acc_ready_i = 1;
          if (v.fl == 1) flush_i = 1;
        end
        @(posedge clk_i); #1 acc_ready_i = 0; flush_i = 0;
        @(negedge clk_i);
        if (c < v.rdy_dly) chk({tag, " valid held"}, acc_valid_o, 1);
      end
      chk({tag, " valid drop"}, acc_valid_o, 0);
      chk({tag, " busy after issue"}, busy_o, v.fl != 1);
      if (v.fl != 1) begin
        for (int c = 0; c <= v.done_dly; c++) begin
          if (v.fl == 2 && c == 0) flush_i = 1;
          if (c == v.done_dly) begin
            acc_done_i = 1; acc_wb_i = v.wb; acc_err_i = v.err; acc_result_i = v.res;
          end
          @(posedge clk_i); #1;
          flush_i = 0; acc_done_i = 0; acc_wb_i = 0; acc_err_i = 0; acc_result_i = $urandom;
          @(negedge clk_i);
        end
      end
      repeat (2) @(negedge clk_i);
    end
    chk({tag, " gnt pulses"}, gnt_cnt - g0, 1);
    chk({tag, " err pulses"}, err_cnt - e0, v.exp_err);
    chk({tag, " retired delta"}, retired_cnt_o - r0, 32'(v.exp_ret));
    chk({tag, " writes"}, wq.size() - w0, 32'(v.exp_we));
    if (v.exp_we && wq.size() > w0) chk({tag, " write data"}, wq[w0], {v.exp_waddr, v.exp_wdata});
    chk({tag, " idle"}, busy_o, 0);
  endtask

  // issue a fixed instruction and complete the ready handshake; returns in WAIT_DONE
  task automatic start_issue(output bit ok);
    @(negedge clk_i);
    exec_req_i = 1; opcode_i = 4'h3; instr_i = 32'h0000_007b; rd_addr_i = 5'd9;
    @(posedge clk_i); #1 exec_req_i = 0;
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (acc_valid_o) begin ok = 1; break; end
    end
    chk("start valid", ok, 1);
    acc_ready_i = 1;
    @(posedge clk_i); #1 acc_ready_i = 0;
  endtask

  vec_t tbl[7];
  initial begin
    bit ok; logic [31:0] r0; int w0, e0;
    tbl[0] = mk(4'h1, 3'd0, 2'd0, 32'h0000_000b, 5'd5, 32'h10, '0, 4'b0000, 0, 0, 0,
                1, 0, 32'hDEADBEEF, 1, 5'd5, 32'hDEADBEEF, 1, 0, '0);
    tbl[1] = mk(4'h2, 3'd1, 2'd1, 32'h1234_567b, 5'd6, 32'h20,
                {32'hFFFFFFFF, 32'h3, 32'h2, 32'h1}, 4'b0111, 1, 2, 0,
                0, 0, 32'h55, 0, 0, 0, 1, 0, {32'h0, 32'h3, 32'h2, 32'h1});
    tbl[2] = mk(4'h1, 3'd2, 2'd0, 32'h0000_000b, 5'd0, 32'h30, '0, 4'b0000, 0, 1, 0,
                1, 0, 32'h77, 0, 0, 0, 1, 0, '0);
    tbl[3] = mk(4'h4, 3'd3, 2'd2, 32'hAAAA_000b, 5'd8, 32'h40, '0, 4'b0000, 2, 1, 0,
                1, 1, 32'h99, 0, 0, 0, 0, 1, '0);
    tbl[4] = mk(4'h5, 3'd4, 2'd3, 32'hBBBB_000b, 5'd10, 32'h50, {4{32'hC0DE0000}}, 4'b1111,
                3, 0, 1, 1, 0, 32'h11, 0, 0, 0, 0, 0, {4{32'hC0DE0000}});
    tbl[5] = mk(4'h6, 3'd5, 2'd1, 32'hCCCC_000b, 5'd7, 32'h60, '0, 4'b0000, 0, 2, 2,
                1, 0, 32'h1234, 0, 0, 0, 0, 0, '0);
    tbl[6] = mk(4'h7, 3'd6, 2'd2, 32'hDDDD_000b, 5'd31, 32'h70,
                {32'hA, 32'hB, 32'hC, 32'hD}, 4'b1010, 2, 3, 0,
                1, 0, 32'hCAFEF00D, 1, 5'd31, 32'hCAFEF00D, 1, 0, {32'hA, 32'h0, 32'hC, 32'h0});

    repeat (2) @(posedge clk_i);
    @(negedge clk_i); chk_zero("reset");
    rst_ni = 1;

    // latency: req at edge N, gnt N+1, valid N+2, write N+4
    @(negedge clk_i);
    exec_req_i = 1; rd_addr_i = 5'd5; rs1_data_i = 32'h10; imm32_valid_i = 0;
    r0 = retired_cnt_o;
    @(posedge clk_i); #1 exec_req_i = 0;
    @(negedge clk_i); chk("lat gnt", {exec_gnt_o, acc_valid_o}, 2'b10);
    @(negedge clk_i); chk("lat valid", {exec_gnt_o, acc_valid_o}, 2'b01);
    acc_ready_i = 1;
    @(posedge clk_i); #1 acc_ready_i = 0;
    @(negedge clk_i); chk("lat wait", {acc_valid_o, x_we_o, busy_o}, 3'b001);
    acc_done_i = 1; acc_wb_i = 1; acc_result_i = 32'hDEADBEEF;
    @(posedge clk_i); #1 acc_done_i = 0; acc_wb_i = 0;
    @(negedge clk_i); chk("lat write", {x_we_o, x_waddr_o, x_wdata_o}, {1'b1, 5'd5, 32'hDEADBEEF});
    @(negedge clk_i); chk("lat after", {x_we_o, busy_o}, 2'b00);
    chk("lat retired", retired_cnt_o - r0, 1);

    // flush beats request in IDLE
    @(negedge clk_i); exec_req_i = 1; flush_i = 1;
    @(posedge clk_i); #1 exec_req_i = 0; flush_i = 0;
    @(negedge clk_i); chk("idle flush", {exec_gnt_o, busy_o}, 2'b00);

    for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      vec_t v; int f;
      f = $urandom_range(0, 5);
      v.fl = (f == 4) ? 1 : (f == 5) ? 2 : 0;
      v.opc = 4'($urandom); v.f3 = 3'($urandom); v.f2 = 2'($urandom); v.instr = $urandom;
      v.rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      v.rs1 = $urandom; v.rs2 = $urandom; v.rs3 = $urandom;
      v.imm = {$urandom, $urandom, $urandom, $urandom}; v.immv = 4'($urandom);
      v.rdy_dly = $urandom_range(0, 3);
      v.done_dly = $urandom_range((v.fl == 2) ? 1 : 0, 3);
      v.wb = 1'($urandom); v.err = ($urandom_range(0, 7) == 0); v.res = $urandom;
      run_txn(model(v), $sformatf("rnd%0d", i));
    end

`ifdef ISOLDE_EXEC_TIMEOUT_EN
    w0 = wq.size(); r0 = retired_cnt_o; e0 = err_cnt;
    start_issue(ok);
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk_i);
      chk($sformatf("wd err k%0d", k), err_o, k == 16);
      if (k >= 16) chk($sformatf("wd busy k%0d", k), busy_o, 0);
    end
    acc_done_i = 1; acc_wb_i = 1; acc_result_i = 32'h5A5A;
    @(posedge clk_i); #1 acc_done_i = 0; acc_wb_i = 0;
    repeat (2) @(negedge clk_i);
    chk("wd stale write", wq.size() - w0, 0);
    chk("wd stale retire", retired_cnt_o - r0, 0);
    chk("wd err once", err_cnt - e0, 1);
`endif

    // reset in WAIT_DONE aborts; later done is ignored
    w0 = wq.size();
    start_issue(ok);
    @(negedge clk_i); rst_ni = 0;
    @(posedge clk_i); #1;
    @(negedge clk_i); chk_zero("mid reset");
    rst_ni = 1;
    acc_done_i = 1; acc_wb_i = 1; acc_result_i = 32'hBAD;
    @(posedge clk_i); #1 acc_done_i = 0; acc_wb_i = 0;
    repeat (2) @(negedge clk_i);
    chk("mid reset no write", wq.size() - w0, 0);
    chk("mid reset idle", {busy_o, retired_cnt_o}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
